exp_add_pipe: RTL and testbench
===============================

EXP_ADD_PIPE -- requirements
Module: exp_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent field width in bits, legal range 4..15.
REQ-002 SHALL have parameter BIAS, default 127: exponent bias subtracted from the sum, legal range 1..2^EXP_W-2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port aExp, input, EXP_W bits: biased exponent of operand A.
REQ-006 SHALL have port bExp, input, EXP_W bits: biased exponent of operand B.
REQ-007 SHALL have port cin, input, 1 bit: mantissa-normalisation carry, added to the exponent sum.
REQ-008 SHALL have port inValid, input, 1 bit: input operands are valid.
REQ-009 SHALL have port inReady, output, 1 bit: the block accepts an input this cycle.
REQ-010 SHALL have port expOut, output, EXP_W bits: biased result exponent.
REQ-011 SHALL have port ovf, output, 1 bit: the result overflowed.
REQ-012 SHALL have port unf, output, 1 bit: the result underflowed.
REQ-013 SHALL have port zeroOut, output, 1 bit: an operand exponent is zero.
REQ-014 SHALL have port specOut, output, 1 bit: an operand exponent is all ones (Inf/NaN).
REQ-015 SHALL have port outValid, output, 1 bit: output fields are valid.
REQ-016 SHALL have port outReady, input, 1 bit: downstream accepts the output.

Function
REQ-017 SHALL be a 2-stage pipeline. Stage 1 registers the raw sum S = aExp + bExp + cin, EXP_W+1 bits, with no loss. It also registers the all-ones flag and the zero flag of each operand. Stage 2 registers the biased result and the output flags.
REQ-018 SHALL compute R = S - BIAS as a signed EXP_W+2-bit value in stage 2.
REQ-019 SHALL apply the following precedence in stage 2, highest first:
- specOut=1 with expOut = all ones, and ovf=unf=zeroOut=0;
- else zeroOut=1 with expOut=0, and ovf=unf=0;
- else if R >= 2^EXP_W-1: ovf=1 with expOut = all ones;
- else if R <= 0: unf=1 with expOut=0;
- else expOut = R[EXP_W-1:0] and all flags 0.
REQ-020 SHALL complete a transfer when the valid and ready signals are both 1 on a rising clk edge.
REQ-021 SHALL let stage 2 load when s2 is empty or outReady=1.
REQ-022 SHALL let stage 1 load when s1 is empty or stage 2 loads this cycle.
REQ-023 SHALL drive inReady equal to the stage-1 load condition; a combinational path from outReady to inReady is permitted.
REQ-024 SHALL have a latency of 2 cycles from input transfer to outValid=1 when outReady is held at 1, and a throughput of 1 result per cycle.
REQ-025 SHALL hold expOut, all flags and outValid stable while outValid=1 and outReady=0.
REQ-026 SHALL neither drop nor duplicate results under backpressure and SHALL preserve order; at most 2 results are in flight.
REQ-027 SHALL accept a new input in the same cycle as an output transfer when the pipeline is full and outReady=1 (simultaneous fill and drain).
REQ-028 SHALL ignore inputs while inValid=0 and create no bubble state; the stage valid bits clear as data drains.
REQ-029 SHALL be don't-care for output data while outValid=0, except during reset (REQ-030).

Reset
REQ-030 SHALL, while rst_n=0 and independent of clk, clear both stage valid bits and drive outValid=0, expOut=0, ovf=0, unf=0, zeroOut=0 and specOut=0.
REQ-031 SHALL discard all in-flight results on reset mid-operation; no result from before reset SHALL appear after it.
REQ-032 SHALL drive inReady=1 during reset.
REQ-033 SHALL accept inputs on the first rising clk edge after rst_n deasserts.

Verification (EXP_W=8, BIAS=127)
REQ-034 SHALL cover the normal case: aExp=130, bExp=131, cin=0, outReady=1 -> 2 cycles later outValid=1, expOut=134, all flags 0.
REQ-035 SHALL cover the carry and both boundaries:
- aExp=127, bExp=127, cin=1 -> expOut=128;
- aExp=200, bExp=200 -> ovf=1, expOut=255;
- aExp=60, bExp=67, cin=0 -> unf=1, expOut=0;
- aExp=1, bExp=126, cin=1 -> expOut=1, no unf.
REQ-036 SHALL cover the specials:
- aExp=255, bExp=0 -> specOut=1, expOut=255, zeroOut=0;
- aExp=0, bExp=100 -> zeroOut=1, expOut=0.
REQ-037 SHALL cover backpressure: hold outReady=0 and offer 3 inputs back-to-back -> 2 accepted, then inReady=0 and the output stays stable. Then raise outReady -> 3 results emerge in order with no loss.
REQ-038 SHALL cover a streaming stall: stream 10 random inputs with outReady toggled randomly -> output sequence matches a reference model exactly, with no gaps while both ends are ready.
REQ-039 SHALL cover reset mid-operation: pulse rst_n=0 asynchronously with 2 results in flight -> outValid=0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/exp_add_pipe.sv
// Two-stage floating-point exponent adder: sums biased exponents plus a normalisation
// carry, removes the bias and resolves specials, zero, overflow and underflow.
module exp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int BIAS  = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [EXP_W-1:0] aExp,
    input  logic [EXP_W-1:0] bExp,
    input  logic             cin,
    input  logic             inValid,
    output logic             inReady,
    output logic [EXP_W-1:0] expOut,
    output logic             ovf,
    output logic             unf,
    output logic             zeroOut,
    output logic             specOut,
    output logic             outValid,
    input  logic             outReady
);

    localparam int SUM_W = EXP_W + 1;
    localparam int R_W   = EXP_W + 2;
    localparam int RES_W = EXP_W + 4;

    localparam logic signed [R_W-1:0] BIAS_S  = R_W'(BIAS);
    localparam logic signed [R_W-1:0] OVF_LIM = R_W'((2 ** EXP_W) - 1);
    localparam logic signed [R_W-1:0] ZERO_S  = '0;
    localparam logic [EXP_W-1:0]      ONES    = '1;

    logic [SUM_W-1:0] sum_p1;
    logic             a_ones_p1, b_ones_p1;
    logic             a_zero_p1, b_zero_p1;
    logic             vld_p1, vld_p2;
    logic             load_p1, load_p2;

    // Result packing is {exponent, ovf, unf, zero, spec}; earlier branches win.
    function automatic logic [RES_W-1:0] resolve(
        input logic [SUM_W-1:0] sum,
        input logic             spec,
        input logic             zero
    );
        logic signed [R_W-1:0] r;
        r = $signed({1'b0, sum}) - BIAS_S;
        if (spec)
            resolve = {ONES, 4'b0001};
        else if (zero)
            resolve = {{EXP_W{1'b0}}, 4'b0010};
        else if (r >= OVF_LIM)
            resolve = {ONES, 4'b1000};
        else if (r <= ZERO_S)
            resolve = {{EXP_W{1'b0}}, 4'b0100};
        else
            resolve = {r[EXP_W-1:0], 4'b0000};
    endfunction

    assign load_p2  = !vld_p2 || outReady;
    assign load_p1  = !vld_p1 || load_p2;
    assign inReady  = load_p1;
    assign outValid = vld_p2;

    // Stage 1: lossless raw sum and per-operand class flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (load_p1)
            vld_p1 <= inValid;
    end

    always_ff @(posedge clk) begin
        if (load_p1 && inValid) begin
            sum_p1    <= SUM_W'(aExp) + SUM_W'(bExp) + SUM_W'(cin);
            a_ones_p1 <= &aExp;
            b_ones_p1 <= &bExp;
            a_zero_p1 <= ~|aExp;
            b_zero_p1 <= ~|bExp;
        end
    end

    // Stage 2: bias removal, saturation and flag resolution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            expOut  <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            zeroOut <= 1'b0;
            specOut <= 1'b0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                {expOut, ovf, unf, zeroOut, specOut} <= resolve(sum_p1,
                                                                a_ones_p1 || b_ones_p1,
                                                                a_zero_p1 || b_zero_p1);
        end
    end

endmodule

// File: tb/tb_exp_add_pipe.sv
// Directed bench for exp_add_pipe (EXP_W=8, BIAS=127): latency, boundaries, specials,
// backpressure, random stall streaming and asynchronous reset with work in flight.
module tb_exp_add_pipe;

    localparam int EXP_W = 8;
    localparam int BIAS  = 127;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [EXP_W-1:0] aExp = '0;
    logic [EXP_W-1:0] bExp = '0;
    logic             cin = 1'b0;
    logic             inValid = 1'b0;
    logic             outReady = 1'b0;
    logic             inReady;
    logic [EXP_W-1:0] expOut;
    logic             ovf, unf, zeroOut, specOut, outValid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    longint      got_t[$];

    always #5 clk = ~clk;

    exp_add_pipe #(.EXP_W(EXP_W), .BIAS(BIAS)) dut (
        .clk(clk), .rst_n(rst_n), .aExp(aExp), .bExp(bExp), .cin(cin),
        .inValid(inValid), .inReady(inReady), .expOut(expOut), .ovf(ovf), .unf(unf),
        .zeroOut(zeroOut), .specOut(specOut), .outValid(outValid), .outReady(outReady)
    );

    function automatic logic [31:0] pack(input logic [7:0] e, input logic o, input logic u,
                                         input logic z, input logic s);
        return {20'd0, e, o, u, z, s};
    endfunction

    function automatic logic [31:0] obs();
        return pack(expOut, ovf, unf, zeroOut, specOut);
    endfunction

    function automatic logic [31:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        int s;
        s = int'(a) + int'(b) + int'(c) - BIAS;
        if (a == 8'hFF || b == 8'hFF) return pack(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        if (a == 8'h00 || b == 8'h00) return pack(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        if (s >= 255)                 return pack(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        if (s <= 0)                   return pack(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        return pack(8'(s), 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
        aExp = a;
        bExp = b;
        cin = c;
        inValid = 1'b1;
    endtask

    // Handshake monitor, sampled on the falling edge ahead of the transferring edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (outValid && outReady) begin
                got_q.push_back(obs());
                got_t.push_back($time);
            end
            if (inValid && inReady)
                exp_q.push_back(model(aExp, bExp, cin));
        end
    end

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
        got_t.delete();
    endtask

    task automatic run_single(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic c, input logic [31:0] expv);
        drive(a, b, c);
        outReady = 1'b1;
        #1 check({tag, "_rdy"}, 32'(inReady), 32'd1);
        step();
        inValid = 1'b0;
        check({tag, "_lat1"}, 32'(outValid), 32'd0);
        step();
        check({tag, "_vld"}, 32'(outValid), 32'd1);
        check(tag, obs(), expv);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  va[6];
        logic [7:0]  vb[6];
        logic        vc[6];
        logic [31:0] ve[6];
        int          acc, cyc;
        logic        took;

        // Reset values before any clock edge
        #2;
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_data", obs(), 32'd0);
        check("rst_inready", 32'(inReady), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First input offered right after release must be taken
        run_single("normal", 8'd130, 8'd131, 1'b0, pack(8'd134, 1'b0, 1'b0, 1'b0, 1'b0));
        run_single("spec",   8'd255, 8'd0,   1'b0, pack(8'd255, 1'b0, 1'b0, 1'b0, 1'b1));
        run_single("zero",   8'd0,   8'd100, 1'b0, pack(8'd0,   1'b0, 1'b0, 1'b1, 1'b0));

        // Back-to-back boundary burst at full throughput
        va = '{8'd127, 8'd200, 8'd60, 8'd1,   8'd190, 8'd191};
        vb = '{8'd127, 8'd200, 8'd67, 8'd126, 8'd191, 8'd191};
        vc = '{1'b1,   1'b0,   1'b0,  1'b1,   1'b0,   1'b0};
        ve = '{pack(8'd128, 1'b0, 1'b0, 1'b0, 1'b0),
               pack(8'd255, 1'b1, 1'b0, 1'b0, 1'b0),
               pack(8'd0,   1'b0, 1'b1, 1'b0, 1'b0),
               pack(8'd1,   1'b0, 1'b0, 1'b0, 1'b0),
               pack(8'd254, 1'b0, 1'b0, 1'b0, 1'b0),
               pack(8'd255, 1'b1, 1'b0, 1'b0, 1'b0)};
        clear_q();
        outReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(va[i], vb[i], vc[i]);
            #1 check("burst_rdy", 32'(inReady), 32'd1);
            step();
        end
        inValid = 1'b0;
        repeat (3) step();
        check("burst_cnt", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("burst_res%0d", i), got_q[i], ve[i]);
                if (i > 0)
                    check($sformatf("burst_gap%0d", i), 32'(got_t[i] - got_t[i-1]), 32'd10);
            end else begin
                check($sformatf("burst_res%0d", i), 32'hDEAD, ve[i]);
            end
        end

        // Backpressure: two accepted, third blocked, output held
        clear_q();
        outReady = 1'b0;
        drive(8'd130, 8'd131, 1'b0);
        #1 check("bp_rdy0", 32'(inReady), 32'd1);
        step();
        drive(8'd200, 8'd200, 1'b0);
        #1 check("bp_rdy1", 32'(inReady), 32'd1);
        step();
        drive(8'd60, 8'd67, 1'b0);
        check("bp_full", 32'(inReady), 32'd0);
        check("bp_vld", 32'(outValid), 32'd1);
        check("bp_head", obs(), pack(8'd134, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) step();
        check("bp_hold_rdy", 32'(inReady), 32'd0);
        check("bp_hold_vld", 32'(outValid), 32'd1);
        check("bp_hold", obs(), pack(8'd134, 1'b0, 1'b0, 1'b0, 1'b0));
        outReady = 1'b1;
        #1 check("bp_release_rdy", 32'(inReady), 32'd1);
        step();
        inValid = 1'b0;
        repeat (4) step();
        check("bp_cnt", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("bp_res0", got_q[0], pack(8'd134, 1'b0, 1'b0, 1'b0, 1'b0));
            check("bp_res1", got_q[1], pack(8'd255, 1'b1, 1'b0, 1'b0, 1'b0));
            check("bp_res2", got_q[2], pack(8'd0,   1'b0, 1'b1, 1'b0, 1'b0));
        end

        // Random stream with random output stalls against the model
        clear_q();
        acc = 0;
        cyc = 0;
        drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        while (acc < 10 && cyc < 300) begin
            outReady = 1'($urandom_range(0, 1));
            #1 took = inReady;
            step();
            if (took) begin
                acc++;
                drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)));
            end
            cyc++;
        end
        inValid = 1'b0;
        outReady = 1'b1;
        cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 10) begin
            step();
            cyc++;
        end
        check("stream_acc", 32'(acc), 32'd10);
        check("stream_exp_cnt", 32'(exp_q.size()), 32'd10);
        check("stream_cnt", 32'(got_q.size()), 32'(exp_q.size()));
        check("stream_drain", 32'(cyc <= 3), 32'd1);
        for (int i = 0; i < 10; i++)
            if (i < got_q.size() && i < exp_q.size())
                check($sformatf("stream_res%0d", i), got_q[i], exp_q[i]);

        // Asynchronous reset with two results in flight
        step();
        clear_q();
        outReady = 1'b0;
        drive(8'd130, 8'd131, 1'b0);
        step();
        drive(8'd127, 8'd127, 1'b1);
        step();
        inValid = 1'b0;
        check("mid_pre_vld", 32'(outValid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(outValid), 32'd0);
        check("mid_rst_data", obs(), 32'd0);
        check("mid_rst_rdy", 32'(inReady), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        outReady = 1'b1;
        drive(8'd100, 8'd100, 1'b0);
        step();
        inValid = 1'b0;
        repeat (4) step();
        check("mid_post_cnt", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1)
            check("mid_post_res", got_q[0], pack(8'd73, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
